// File: rtl/bp_be_fe_queue.sv
// ---------------------------------------------------------------------------
// bp_be_fe_queue
//
// Checkpointed instruction queue between the front-end fetch output and the
// back-end checker. Fetch packets enqueue with ready/valid. The checker reads
// them speculatively with yumi. Entries are then either committed (deq),
// re-presented from the last commit point (roll), or dropped wholesale (clr).
// Every output is a function of registered state only, so no combinational
// path exists from the FE side to the BE side.
//
// Ports:
//   clk_i      - clock, all state updates on the rising edge
//   reset_n_i  - synchronous active-low reset (clears the pointers only)
//   data_i     - fetch packet to enqueue
//   v_i        - enqueue valid
//   ready_o    - space available (space is freed on commit, not on read)
//   data_o     - entry at the speculative read pointer
//   v_o        - an unread entry is present
//   yumi_i     - checker consumes data_o this cycle (only while v_o)
//   deq_i      - commit the oldest speculatively read entry
//   roll_i     - rewind the speculative read pointer to the commit pointer
//   clr_i      - discard all unread entries
//   empty_o    - nothing held, committed or otherwise
// ---------------------------------------------------------------------------
module bp_be_fe_queue #(
  parameter  int width_p      = 128,
  parameter  int els_p        = 8,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               deq_i,
  input  logic               roll_i,
  input  logic               clr_i,
  output logic               empty_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] full_cnt_lp = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] one_lp      = ptr_width_lp'(1);

  logic [width_p-1:0] mem_q [els_p];

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  logic [ptr_width_lp-1:0] wptr_q,      wptr_d;
  logic [ptr_width_lp-1:0] rptr_spec_q, rptr_spec_d;
  logic [ptr_width_lp-1:0] rptr_cmt_q,  rptr_cmt_d;

  logic [ptr_width_lp-1:0] used_cnt;
  logic                    enq;

  // Occupancy is measured from the commit pointer: read-but-uncommitted
  // entries still own their slots because a roll may re-present them.
  assign used_cnt = wptr_q - rptr_cmt_q;
  assign ready_o  = (used_cnt != full_cnt_lp);
  assign v_o      = (rptr_spec_q != wptr_q);
  assign empty_o  = (wptr_q == rptr_cmt_q);
  assign data_o   = mem_q[rptr_spec_q[idx_width_lp-1:0]];

  // A packet arriving in the same cycle as a clear is dropped.
  assign enq = v_i & ready_o & ~clr_i;

  always_comb begin
    rptr_cmt_d  = rptr_cmt_q;
    rptr_spec_d = rptr_spec_q;
    wptr_d      = wptr_q;

    if (deq_i) begin
      rptr_cmt_d = rptr_cmt_q + one_lp;
    end

    // Roll lands on the post-commit pointer and voids a concurrent yumi.
    if (roll_i) begin
      rptr_spec_d = rptr_cmt_d;
    end else if (yumi_i) begin
      rptr_spec_d = rptr_spec_q + one_lp;
    end

    // Clear truncates the queue at the new speculative pointer, so an entry
    // yumi'd in the same cycle survives as read-but-uncommitted.
    if (clr_i) begin
      wptr_d = rptr_spec_d;
    end else if (enq) begin
      wptr_d = wptr_q + one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q      <= '0;
      rptr_spec_q <= '0;
      rptr_cmt_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_spec_q <= rptr_spec_d;
      rptr_cmt_q  <= rptr_cmt_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
    end
  end

  // Protocol checks on the checker and fetch sides.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);
  a_deq_needs_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_i |-> (rptr_cmt_q != rptr_spec_q));
  a_no_valid_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    v_i |-> ready_o);

endmodule

// File: tb/tb_bp_be_fe_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_be_fe_queue
//
// Directed scenarios plus a short random phase for bp_be_fe_queue. The driver
// keeps a reference model (a list of held entries plus a count of how many are
// speculatively read) and pushes the expected packet for every yumi into a
// scoreboard queue; an independent monitor pops and compares whenever the DUT
// presents data that the checker consumes.
// ---------------------------------------------------------------------------
module tb_bp_be_fe_queue;

  localparam int W = 128;
  localparam int N = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic         v_in;
  logic         ready;
  logic [W-1:0] data_out;
  logic         v_out;
  logic         yumi;
  logic         deq;
  logic         roll;
  logic         clr;
  logic         empty;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];   // scoreboard: expected packet per yumi
  logic [W-1:0] m_q   [$];   // model: held entries, oldest first
  int           m_ns  = 0;   // model: number of those already read

  bp_be_fe_queue #(.width_p(W), .els_p(N)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .data_i    (data_in),
    .v_i       (v_in),
    .ready_o   (ready),
    .data_o    (data_out),
    .v_o       (v_out),
    .yumi_i    (yumi),
    .deq_i     (deq),
    .roll_i    (roll),
    .clr_i     (clr),
    .empty_o   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: every consumed packet is compared against the scoreboard.
  always @(negedge clk) begin
    if (yumi) begin
      check("mon_v_o_on_yumi", W'(v_out), W'(1));
      if (exp_q.size() == 0) begin
        check("mon_sb_underflow", W'(1), W'(0));
      end else begin
        check("mon_data_o", data_out, exp_q.pop_front());
      end
    end
  end

  // Compare status outputs against the model in the current (stable) state.
  task automatic check_status();
    logic m_v;
    m_v = (m_ns < m_q.size());
    check("v_o", W'(v_out), W'(m_v));
    check("ready_o", W'(ready), W'(m_q.size() < N));
    check("empty_o", W'(empty), W'(m_q.size() == 0));
    if (m_v) check("data_o", data_out, m_q[m_ns]);
  endtask

  // One clock of stimulus. Requests are trimmed to what is legal for the
  // model state so the protocol assertions stay quiet.
  task automatic cycle(input logic rst_n, input logic v, input logic [W-1:0] d,
                       input logic y, input logic dq, input logic rl, input logic cl);
    logic m_ready;
    logic enq;
    check_status();
    m_ready = (m_q.size() < N);
    reset_n = rst_n;
    v_in    = v & m_ready;
    data_in = d;
    yumi    = y & (m_ns < m_q.size());
    deq     = dq & (m_ns > 0);
    roll    = rl;
    clr     = cl;
    if (yumi) exp_q.push_back(m_q[m_ns]);
    enq = v_in & m_ready & ~clr;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_ns = 0;
    end else begin
      if (deq) begin
        void'(m_q.pop_front());
        m_ns--;
      end
      if (roll) m_ns = 0;
      else if (yumi) m_ns++;
      if (clr) begin
        while (m_q.size() > m_ns) void'(m_q.pop_back());
      end else if (enq) begin
        m_q.push_back(d);
      end
    end
    #1;
    v_in = 1'b0; yumi = 1'b0; deq = 1'b0; roll = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; data_in = '0; v_in = 1'b0; yumi = 1'b0;
    deq = 1'b0; roll = 1'b0; clr = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_ready", W'(ready), W'(1));
    check("rst_v", W'(v_out), W'(0));
    check("rst_empty", W'(empty), W'(1));

    // Fill with 0x1..0x8
    for (int i = 1; i <= N; i++) begin
      cycle(1'b1, 1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1) check("fill_v_latency", W'(v_out), W'(1));
    end
    check("fill_ready_low", W'(ready), W'(0));
    check("fill_data", data_out, W'(1));
    check("fill_empty", W'(empty), W'(0));

    // Read 1,2,3 speculatively, commit one, roll back
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("spec_data_4", data_out, W'(4));
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("roll_data", data_out, W'(2));
    check("roll_ready", W'(ready), W'(1));

    // Reach 5 held (4..8), read 2, then clear with 0x9 arriving
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_clr_data", data_out, W'(4));
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(9), 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_v", W'(v_out), W'(0));
    check("clr_empty", W'(empty), W'(0));
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_deq_empty", W'(empty), W'(1));
    cycle(1'b1, 1'b1, W'('hA), 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_dropped_9", data_out, W'('hA));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // roll + yumi: yumi is void, 0x11 presented again
    cycle(1'b1, 1'b1, W'('h11), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'('h12), 1'b1, 1'b0, 1'b0, 1'b0);
    check("ry_before", data_out, W'('h12));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("roll_yumi_data", data_out, W'('h11));
    // clr + roll: fully empty
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_roll_empty", W'(empty), W'(1));
    check("clr_roll_v", W'(v_out), W'(0));

    // Random stress, including many pointer wraps
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, ($urandom_range(9) < 7), {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(9) < 5), ($urandom_range(9) < 4),
            ($urandom_range(19) == 0), ($urandom_range(19) == 0));
    end
    // Concurrent enq/yumi/deq stream across the wrap boundary
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2 * N + 4; i++) begin
      cycle(1'b1, 1'b1, W'('h100 + i), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Reset mid-operation with queue full and yumi/deq active
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, W'('h200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_ready", W'(ready), W'(0));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_empty", W'(empty), W'(1));
    check("midrst_ready", W'(ready), W'(1));
    check("midrst_v", W'(v_out), W'(0));

    idle(2);
    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
